// File: rtl/jtkcpu_memopnd.sv
// jtkcpu_memopnd: memory-operand sequencer in front of the ALU for indexed ops.
// It turns a resolved effective address into one or two byte reads, or one or
// two byte writes, on the 8-bit bus. 16-bit data is big-endian: the high byte
// is at ea and the low byte is at ea+1, with ea+1 wrapping from FFFF to 0000.
// Optional feature macro: JTKCPU_MEMOPND_RMW_EN. It enables read-modify-write:
// read, wait for the ALU, then write alu_rslt back to the same address.
//
// Handshake: start is a request that is taken only on a cen edge while the
// sequencer is IDLE. While busy=1, start is ignored and is not queued. done is
// a single cen-cycle pulse. It marks a valid opnd after a read, or a finished
// write. A start seen on the edge where done is high is accepted, because the
// state is already IDLE at that edge. This gives back-to-back operation.
module jtkcpu_memopnd (
  input  logic        clk,
  input  logic        rst,
  input  logic        cen,
  input  logic        start,
  input  logic        wr,
  input  logic        wide,
  input  logic        rmw,
  input  logic [15:0] ea,
  input  logic [15:0] wdata,
  input  logic [15:0] alu_rslt,
  input  logic        alu_busy,
  input  logic        bus_wait,
  input  logic [7:0]  din,
  output logic [15:0] addr,
  output logic        we,
  output logic [7:0]  dout,
  output logic [15:0] opnd,
  output logic        done,
  output logic        busy,
  output logic [2:0]  state_dbg
);

`ifdef JTKCPU_MEMOPND_RMW_EN
  localparam logic RMW_EN = 1'b1;
`else
  localparam logic RMW_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_HI    = 3'd1,
    RD_LO    = 3'd2,
    WR_HI    = 3'd3,
    WR_LO    = 3'd4,
    RMW_WAIT = 3'd5
  } state_t;

  state_t      state, state_nx;
  logic [15:0] ea_q, ea_nx;
  logic [15:0] data_q, data_nx;
  logic        wide_q, wide_nx;
  logic        rmw_q, rmw_nx;
  logic [15:0] addr_nx;
  logic        we_nx;
  logic [7:0]  dout_nx;
  logic [15:0] opnd_nx;
  logic        done_nx;
  logic        busy_nx;

  assign state_dbg = state;

  // State and output registers: async reset, advance only on cen edges
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      ea_q   <= 16'h0000;
      data_q <= 16'h0000;
      wide_q <= 1'b0;
      rmw_q  <= 1'b0;
      addr   <= 16'h0000;
      we     <= 1'b0;
      dout   <= 8'h00;
      opnd   <= 16'h0000;
      done   <= 1'b0;
      busy   <= 1'b0;
    end else if (cen) begin
      state  <= state_nx;
      ea_q   <= ea_nx;
      data_q <= data_nx;
      wide_q <= wide_nx;
      rmw_q  <= rmw_nx;
      addr   <= addr_nx;
      we     <= we_nx;
      dout   <= dout_nx;
      opnd   <= opnd_nx;
      done   <= done_nx;
      busy   <= busy_nx;
    end
  end

  // Next-state and next-output logic; bus_wait=1 keeps every access where it is
  always_comb begin
    state_nx = state;
    ea_nx    = ea_q;
    data_nx  = data_q;
    wide_nx  = wide_q;
    rmw_nx   = rmw_q;
    addr_nx  = addr;
    we_nx    = we;
    dout_nx  = dout;
    opnd_nx  = opnd;
    done_nx  = 1'b0;
    busy_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          ea_nx   = ea;
          data_nx = wdata;
          wide_nx = wide;
          // rmw only makes sense on the read path; it is tied off without the feature
          rmw_nx  = rmw & RMW_EN & ~wr;
          addr_nx = ea;
          if (wr) begin
            we_nx    = 1'b1;
            dout_nx  = wide ? wdata[15:8] : wdata[7:0];
            state_nx = wide ? WR_HI : WR_LO;
          end else begin
            state_nx = wide ? RD_HI : RD_LO;
          end
        end
      end
      RD_HI: begin
        if (!bus_wait) begin
          opnd_nx[15:8] = din;
          addr_nx       = addr + 16'd1;
          state_nx      = RD_LO;
        end
      end
      RD_LO: begin
        if (!bus_wait) begin
          opnd_nx  = {(wide_q ? opnd[15:8] : 8'h00), din};
          done_nx  = 1'b1;
          state_nx = rmw_q ? RMW_WAIT : IDLE;
        end
      end
      WR_HI: begin
        if (!bus_wait) begin
          addr_nx  = addr + 16'd1;
          dout_nx  = data_q[7:0];
          state_nx = WR_LO;
        end
      end
      WR_LO: begin
        if (!bus_wait) begin
          we_nx    = 1'b0;
          done_nx  = 1'b1;
          state_nx = IDLE;
        end
      end
      RMW_WAIT: begin
        // The ALU result is captured here, so the low byte of a 16-bit write-back is stable
        if (!alu_busy) begin
          addr_nx  = ea_q;
          data_nx  = alu_rslt;
          rmw_nx   = 1'b0;
          we_nx    = 1'b1;
          dout_nx  = wide_q ? alu_rslt[15:8] : alu_rslt[7:0];
          state_nx = wide_q ? WR_HI : WR_LO;
        end
      end
      default: begin
        state_nx = IDLE;
        we_nx    = 1'b0;
      end
    endcase
    busy_nx = (state_nx != IDLE);
  end

endmodule

// File: tb/tb_jtkcpu_memopnd.sv
// Testbench for jtkcpu_memopnd. It uses a directed vector table, hand-written
// corner sequences, and randomized transactions. All of these are checked
// against a byte-addressed memory model and the access rules.
module tb_jtkcpu_memopnd;

  logic        clk = 1'b0;
  logic        rst, cen, start, wr, wide, rmw;
  logic [15:0] ea, wdata, alu_rslt;
  logic        alu_busy, bus_wait;
  logic [7:0]  din;
  logic [15:0] addr;
  logic        we;
  logic [7:0]  dout;
  logic [15:0] opnd;
  logic        done, busy;
  logic [2:0]  state_dbg;

  int checks = 0;
  int failures = 0;

  logic [7:0]  mem [0:65535];
  logic [23:0] exp_q[$];

  typedef struct {
    logic        wr;
    logic        wide;
    logic [15:0] ea;
    logic [15:0] wdata;
    logic [7:0]  b0;
    logic [7:0]  b1;
    int          waits;
    logic [15:0] exp_opnd;
  } vec_t;

  vec_t vecs[7];

  jtkcpu_memopnd dut (
    .clk(clk), .rst(rst), .cen(cen), .start(start), .wr(wr), .wide(wide),
    .rmw(rmw), .ea(ea), .wdata(wdata), .alu_rslt(alu_rslt), .alu_busy(alu_busy),
    .bus_wait(bus_wait), .din(din), .addr(addr), .we(we), .dout(dout),
    .opnd(opnd), .done(done), .busy(busy), .state_dbg(state_dbg)
  );

  // Clock
  always #5 clk = ~clk;

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  // Model the bus around a clock edge: commit a completing write, then drive din
  task automatic tick();
    logic [23:0] got;
    logic [23:0] expv;
    if (cen && !bus_wait && we && !rst) begin
      got = {addr, dout};
      if (exp_q.size() == 0) begin
        chk("unexpected_write", got, 24'h0);
      end else begin
        expv = exp_q.pop_front();
        chk("bus_write", got, expv);
      end
      mem[addr] = dout;
    end
    @(posedge clk);
    #1;
    din = mem[addr];
  endtask

  function automatic logic [15:0] model_read(input logic [15:0] a, input logic w);
    logic [15:0] a1;
    a1 = a + 16'd1;
    return w ? {mem[a], mem[a1]} : {8'h00, mem[a]};
  endfunction

  // One transaction: start on a cen edge, then follow every edge until done is expected
  task automatic run_txn(input logic t_wr, input logic t_wide, input logic [15:0] t_ea,
                         input logic [15:0] t_wdata, input int t_waits,
                         input logic [15:0] t_exp, input bit t_rand, input bit t_noise);
    int          acc_total, acc_done, w_left, edges;
    logic [15:0] ea1, p_addr;
    logic        p_we, p_done;
    logic [7:0]  p_dout, first_b, second_b;
    ea1       = t_ea + 16'd1;
    acc_total = t_wide ? 2 : 1;
    first_b   = t_wide ? t_wdata[15:8] : t_wdata[7:0];
    second_b  = t_wdata[7:0];
    if (t_wr) begin
      exp_q.push_back({t_ea, first_b});
      if (t_wide) exp_q.push_back({ea1, second_b});
    end
    start = 1'b1; wr = t_wr; wide = t_wide; ea = t_ea; wdata = t_wdata;
    rmw = 1'b0; cen = 1'b1; bus_wait = 1'b0;
    tick();
    start = 1'b0;
    chk("start_addr", addr, t_ea);
    chk("start_busy", busy, 1);
    chk("start_done", done, 0);
    chk("start_we", we, t_wr);
    if (t_wr) chk("start_dout", dout, first_b);
    acc_done = 0;
    w_left   = t_waits;
    edges    = 0;
    while (acc_done < acc_total && edges < 200) begin
      cen      = t_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus_wait = t_rand ? ($urandom_range(0, 2) == 0) : (w_left > 0);
      if (t_noise) begin
        start = $urandom_range(0, 1);
        wr    = $urandom_range(0, 1);
        wide  = $urandom_range(0, 1);
        ea    = 16'($urandom);
        wdata = 16'($urandom);
      end
      p_addr = addr; p_we = we; p_done = done; p_dout = dout;
      tick();
      edges++;
      if (!cen) begin
        chk("hold_addr", addr, p_addr);
        chk("hold_we", we, p_we);
        chk("hold_done", done, p_done);
        chk("hold_dout", dout, p_dout);
      end else begin
        if (bus_wait) begin
          if (w_left > 0) w_left--;
        end else begin
          acc_done++;
        end
        if (acc_done < acc_total) begin
          chk("acc_addr", addr, (acc_done == 0) ? t_ea : ea1);
          chk("acc_done_low", done, 0);
          chk("acc_busy", busy, 1);
          chk("acc_we", we, t_wr);
          if (t_wr) chk("acc_dout", dout, (acc_done == 0) ? first_b : second_b);
        end else begin
          chk("end_done", done, 1);
          chk("end_busy", busy, 0);
          chk("end_we", we, 0);
          if (!t_wr) chk("end_opnd", opnd, t_exp);
        end
      end
    end
    start = 1'b0;
    cen   = 1'b1;
    bus_wait = 1'b0;
    if (acc_done < acc_total) begin
      checks++;
      failures++;
      $display("FAIL txn_timeout got=%0d accesses expected=%0d", acc_done, acc_total);
    end
    chk("writes_left", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    int          n, dn, r;
    logic        t_wr, t_wide;
    logic [15:0] t_ea, t_wd;

    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    rst = 1'b1; cen = 1'b0; start = 1'b0; wr = 1'b0; wide = 1'b0; rmw = 1'b0;
    ea = 16'h0; wdata = 16'h0; alu_rslt = 16'h0; alu_busy = 1'b0; bus_wait = 1'b0;
    din = 8'h00;

    // Reset state
    #3;
    chk("rst_addr", addr, 16'h0000);
    chk("rst_we", we, 0);
    chk("rst_dout", dout, 8'h00);
    chk("rst_opnd", opnd, 16'h0000);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    cen = 1'b1;
    tick();
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);

    // Directed vector table
    vecs[0] = '{1'b0, 1'b0, 16'h1234, 16'h0000, 8'h5A, 8'h00, 0, 16'h005A};
    vecs[1] = '{1'b0, 1'b1, 16'hFFFF, 16'h0000, 8'h12, 8'h34, 0, 16'h1234};
    vecs[2] = '{1'b1, 1'b1, 16'h2000, 16'hBEEF, 8'h00, 8'h00, 3, 16'h0000};
    vecs[3] = '{1'b1, 1'b0, 16'h4000, 16'h00C3, 8'h00, 8'h00, 0, 16'h0000};
    vecs[4] = '{1'b0, 1'b1, 16'h0100, 16'h0000, 8'hAB, 8'hCD, 2, 16'hABCD};
    vecs[5] = '{1'b0, 1'b0, 16'h0200, 16'h0000, 8'hFF, 8'hEE, 1, 16'h00FF};
    vecs[6] = '{1'b1, 1'b1, 16'hFFFF, 16'h1357, 8'h00, 8'h00, 1, 16'h0000};
    for (int i = 0; i < 7; i++) begin
      if (!vecs[i].wr) begin
        mem[vecs[i].ea] = vecs[i].b0;
        mem[vecs[i].ea + 16'd1] = vecs[i].b1;
      end
      run_txn(vecs[i].wr, vecs[i].wide, vecs[i].ea, vecs[i].wdata, vecs[i].waits,
              vecs[i].exp_opnd, 1'b0, 1'b0);
      tick();
      chk("vec_done_cleared", done, 0);
    end
    chk("wrap_write_hi", mem[16'hFFFF], 8'h13);
    chk("wrap_write_lo", mem[16'h0000], 8'h57);

    // A start held during a 16-bit read is ignored; the next start is taken back-to-back
    mem[16'h6000] = 8'h9A; mem[16'h6001] = 8'hBC; mem[16'h6002] = 8'h44;
    run_txn(1'b0, 1'b1, 16'h6000, 16'h0000, 1, 16'h9ABC, 1'b0, 1'b1);
    run_txn(1'b0, 1'b0, 16'h6002, 16'h0000, 0, 16'h0044, 1'b0, 1'b0);
    tick();
    chk("b2b_done_cleared", done, 0);
    chk("b2b_idle", busy, 0);

    // Reset during the low byte of a 16-bit write
    exp_q.push_back({16'h5000, 8'hA1});
    start = 1'b1; wr = 1'b1; wide = 1'b1; ea = 16'h5000; wdata = 16'hA1B2; cen = 1'b1; bus_wait = 1'b0;
    tick();
    start = 1'b0;
    tick();
    bus_wait = 1'b1;
    tick();
    chk("rstmid_addr", addr, 16'h5001);
    chk("rstmid_we_before", we, 1);
    #2 rst = 1'b1;
    #1;
    chk("rstmid_we", we, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_done", done, 0);
    chk("rstmid_addr0", addr, 16'h0000);
    tick();
    tick();
    rst = 1'b0;
    bus_wait = 1'b0;
    dn = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done) dn++;
      chk("rstmid_idle_busy", busy, 0);
    end
    chk("rstmid_no_done", dn, 0);
    chk("rstmid_no_writes", exp_q.size(), 0);
    exp_q.delete();

`ifdef JTKCPU_MEMOPND_RMW_EN
    // Read-modify-write: read 0001, ALU busy for 4 cycles, write back 0010
    mem[16'h3000] = 8'h00; mem[16'h3001] = 8'h01;
    start = 1'b1; wr = 1'b0; wide = 1'b1; rmw = 1'b1; ea = 16'h3000;
    cen = 1'b1; bus_wait = 1'b0; alu_busy = 1'b1; alu_rslt = 16'hDEAD;
    tick();
    start = 1'b0; rmw = 1'b0;
    n = 0;
    while (!done && n < 20) begin tick(); n++; end
    chk("rmw_rd_done", done, 1);
    chk("rmw_opnd", opnd, 16'h0001);
    chk("rmw_busy", busy, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rmw_wait_we", we, 0);
      chk("rmw_wait_done", done, 0);
      chk("rmw_wait_busy", busy, 1);
    end
    exp_q.push_back({16'h3000, 8'h00});
    exp_q.push_back({16'h3001, 8'h10});
    alu_busy = 1'b0; alu_rslt = 16'h0010;
    dn = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done) dn++;
    end
    chk("rmw_wr_dones", dn, 1);
    chk("rmw_writes_left", exp_q.size(), 0);
    chk("rmw_end_busy", busy, 0);
    exp_q.delete();
`else
    // Without read-modify-write support, rmw is ignored and the read ends in IDLE
    mem[16'h3000] = 8'h00; mem[16'h3001] = 8'h01;
    start = 1'b1; wr = 1'b0; wide = 1'b1; rmw = 1'b1; ea = 16'h3000;
    cen = 1'b1; bus_wait = 1'b0; alu_busy = 1'b1;
    tick();
    start = 1'b0; rmw = 1'b0;
    n = 0;
    while (!done && n < 20) begin tick(); n++; end
    chk("normw_done", done, 1);
    chk("normw_opnd", opnd, 16'h0001);
    chk("normw_busy", busy, 0);
    dn = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done || we) dn++;
    end
    chk("normw_quiet", dn, 0);
    alu_busy = 1'b0;
`endif

    // Randomized transactions against the memory model
    for (int k = 0; k < 60; k++) begin
      t_wr   = $urandom_range(0, 1);
      t_wide = $urandom_range(0, 1);
      t_ea   = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      t_wd   = 16'($urandom);
      run_txn(t_wr, t_wide, t_ea, t_wd, 0, model_read(t_ea, t_wide), 1'b1, 1'b0);
      r = $urandom_range(0, 2);
      if (r == 1) begin
        cen = 1'b0;
        tick();
        chk("rand_done_stretch", done, 1);
        cen = 1'b1;
        tick();
        chk("rand_done_clear", done, 0);
      end else if (r == 2) begin
        tick();
        chk("rand_done_clear", done, 0);
        chk("rand_idle", busy, 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
